pcs_tx_gear: RTL and testbench

- 100BASE-X PCS transmit process with a parametrised serialiser gearbox that emits BITS code bits per clock.
- Takes MII nibbles and performs 4b/5b encoding plus /J/K/ SSD, /T/R/ ESD and /H/ error insertion.
- Generates its own MII clock enable (tx_ce) from gearbox occupancy, so the MAC side and the PMA side share one fast clock.
- Replaces the fixed 1-bit transmit path; feeds the PMA transmit serialiser.

---
 rtl/pcs_tx_gear_pkg.sv | 16 +
 rtl/pcs_tx_gear_if.sv | 14 +
 rtl/pcs_tx_gearbox.sv | 39 +++
 rtl/pcs_tx_gear.sv | 86 ++++++++
 tb/tb_pcs_tx_gear.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pcs_tx_gear_pkg.sv
// pcs_tx_gear_pkg: code groups, 4b/5b table and transmit state encoding shared by the PCS transmit path
package pcs_tx_gear_pkg;
    localparam logic [4:0] CODE_I = 5'b11111;
    localparam logic [4:0] CODE_J = 5'b11000;
    localparam logic [4:0] CODE_K = 5'b10001;
    localparam logic [4:0] CODE_T = 5'b01101;
    localparam logic [4:0] CODE_R = 5'b00111;
    localparam logic [4:0] CODE_H = 5'b00100;
    localparam logic [4:0] CODE_4B5B [16] = '{
        5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011, 5'b01110, 5'b01111,
        5'b10010, 5'b10011, 5'b10110, 5'b10111, 5'b11010, 5'b11011, 5'b11100, 5'b11101
    };
    typedef enum logic [3:0] {
        IDLE, START_J, START_K, ERROR_J, ERROR_K, DATA, ERROR, END_T, END_R
    } state_t;
endpackage

// File: rtl/pcs_tx_gear_if.sv
// pcs_tx_gear_if: MII transmit side plus PMA code-bit output
//   tx_ce/tx_en/txd/tx_er : MII nibble transfer, sampled when tx_ce=1
//   pma_data_tx           : BITS code bits per clock, MSB first on the wire
//   tx                    : transmitting indication
interface pcs_tx_gear_if #(parameter int BITS = 2);
    logic            tx_ce;
    logic            tx_en;
    logic [3:0]      txd;
    logic            tx_er;
    logic            tx;
    logic [BITS-1:0] pma_data_tx;
    modport master (input tx_ce, tx, pma_data_tx, output tx_en, txd, tx_er);
    modport slave  (output tx_ce, tx, pma_data_tx, input tx_en, txd, tx_er);
endinterface

// File: rtl/pcs_tx_gearbox.sv
// pcs_tx_gearbox: 5-to-BITS serialiser gearbox with occupancy-driven code group request
//   code  : 5-bit group appended (MSB first) on edges where tx_ce=1
//   tx_ce : registered request for the next code group
//   data  : registered BITS oldest bits, [BITS-1] first on the wire
module pcs_tx_gearbox #(
    parameter int BITS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      code,
    output logic            tx_ce,
    output logic [BITS-1:0] data
);
    localparam int W = BITS + 4;
    // Buffer is left-aligned: valid bits occupy [W-1 -: fill], everything below is zero.
    logic [W-1:0] sr, rem, sr_nxt;
    logic [W+4:0] ins;
    logic [3:0]   fill, fill_nxt;
    always_comb begin
        rem      = sr << BITS;
        ins      = {code, {W{1'b0}}} >> (fill - 4'(BITS));
        sr_nxt   = tx_ce ? rem | ins[W+4:5] : rem;
        fill_nxt = fill - 4'(BITS) + (tx_ce ? 4'd5 : 4'd0);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr    <= '1;
            fill  <= 4'(W);
            data  <= '1;
            tx_ce <= (W < 2 * BITS);
        end else begin
            sr    <= sr_nxt;
            fill  <= fill_nxt;
            data  <= sr[W-1 -: BITS];
            // Requesting below 2*BITS keeps fill within [BITS, BITS+4].
            tx_ce <= fill_nxt < 4'(2 * BITS);
        end
    end
endmodule

// File: rtl/pcs_tx_gear.sv
// pcs_tx_gear: 100BASE-X PCS transmit (4b/5b, SSD/ESD, /H/) feeding a BITS-wide gearbox
//   clk, rst    : single clock, asynchronous active-high reset
//   link_status : PMA link up; low on a tx_ce edge forces IDLE
//   bus         : MII nibbles in, tx_ce/tx/pma_data_tx out
//   stats_clr, frames_cnt, err_cnt, abort_cnt : present only with PCS_TX_GEAR_STATS_EN
module pcs_tx_gear
    import pcs_tx_gear_pkg::*;
#(
    parameter int BITS = 2
`ifdef PCS_TX_GEAR_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         link_status,
    pcs_tx_gear_if.slave bus
`ifdef PCS_TX_GEAR_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] frames_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] abort_cnt
`endif
);
    state_t     state, state_nxt, body_nxt;
    logic [3:0] dreg;
    logic [4:0] code;
    logic       tx_nxt, frame_start;
    always_comb begin
        body_nxt    = !bus.tx_en ? END_T : bus.tx_er ? ERROR : DATA;
        frame_start = link_status && state == IDLE && bus.tx_en;
        code        = !link_status                       ? CODE_I :
                      (state == START_J || state == ERROR_J) ? CODE_J :
                      (state == START_K || state == ERROR_K) ? CODE_K :
                      state == DATA                      ? CODE_4B5B[dreg] :
                      state == ERROR                     ? CODE_H :
                      state == END_T                     ? CODE_T :
                      state == END_R                     ? CODE_R : CODE_I;
        state_nxt   = !link_status       ? IDLE :
                      state == IDLE      ? (bus.tx_en ? (bus.tx_er ? ERROR_J : START_J) : IDLE) :
                      state == START_J   ? (bus.tx_er ? ERROR_K : START_K) :
                      state == ERROR_J   ? ERROR_K :
                      state == ERROR_K   ? ERROR :
                      state == END_T     ? END_R :
                      state == END_R     ? IDLE : body_nxt;
        tx_nxt      = !link_status ? 1'b0 : frame_start ? 1'b1 : state == END_T ? 1'b0 : bus.tx;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            bus.tx <= 1'b0;
            dreg   <= '0;
        end else if (bus.tx_ce) begin
            state  <= state_nxt;
            bus.tx <= tx_nxt;
            dreg   <= bus.txd;
        end
    end
    pcs_tx_gearbox #(.BITS(BITS)) u_gear (
        .clk   (clk),
        .rst   (rst),
        .code  (code),
        .tx_ce (bus.tx_ce),
        .data  (bus.pma_data_tx)
    );
`ifdef PCS_TX_GEAR_STATS_EN
    logic aborting;
    assign aborting = !link_status && !(state inside {IDLE, END_T, END_R});
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {frames_cnt, err_cnt, abort_cnt} <= '0;
        end else if (stats_clr) begin
            {frames_cnt, err_cnt, abort_cnt} <= '0;
        end else if (bus.tx_ce) begin
            if (frame_start && !(&frames_cnt))
                frames_cnt <= frames_cnt + CNT_W'(1);
            if (link_status && state == ERROR && !(&err_cnt))
                err_cnt <= err_cnt + CNT_W'(1);
            if (aborting && !(&abort_cnt))
                abort_cnt <= abort_cnt + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_pcs_tx_gear.sv
// tb_pcs_tx_gear: directed and random frames on five gearbox widths, wire stream decoded back to code groups
module tb_pcs_tx_gear;
    localparam logic [4:0] C_I = 5'b11111, C_J = 5'b11000, C_K = 5'b10001;
    localparam logic [4:0] C_T = 5'b01101, C_R = 5'b00111, C_H = 5'b00100;
    localparam logic [4:0] ENC [16] = '{
        5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011, 5'b01110, 5'b01111,
        5'b10010, 5'b10011, 5'b10110, 5'b10111, 5'b11010, 5'b11011, 5'b11100, 5'b11101
    };

    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic       link [5];
    logic       en_a [5], er_a [5], ce_a [5], tx_a [5];
    logic [3:0] d_a [5];
    logic [4:0] pd [5];
    logic [3:0] fill_a [5];
`ifdef PCS_TX_GEAR_STATS_EN
    logic        clr = 0;
    logic [15:0] fc [5], ec [5], ac [5];
`endif

    for (genvar g = 0; g < 5; g++) begin : L
        pcs_tx_gear_if #(.BITS(g + 1)) b ();
        pcs_tx_gear #(
            .BITS(g + 1)
`ifdef PCS_TX_GEAR_STATS_EN
            , .CNT_W(16)
`endif
        ) u (
            .clk         (clk),
            .rst         (rst),
            .link_status (link[g]),
            .bus         (b)
`ifdef PCS_TX_GEAR_STATS_EN
            , .stats_clr (clr),
            .frames_cnt  (fc[g]),
            .err_cnt     (ec[g]),
            .abort_cnt   (ac[g])
`endif
        );
        assign b.tx_en   = en_a[g];
        assign b.tx_er   = er_a[g];
        assign b.txd     = d_a[g];
        assign ce_a[g]   = b.tx_ce;
        assign tx_a[g]   = b.tx;
        assign pd[g]     = 5'(b.pma_data_tx);
        assign fill_a[g] = u.u_gear.fill;
    end

    int checks = 0, errors = 0;
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wire capture, tx_ce counting, fill bound and BITS=1 tx_ce spacing monitors.
    logic wb [5][8192];
    int   wcnt [5] = '{default: 0};
    int   cecnt [5] = '{default: 0};
    int   viol = 0, gapviol = 0, cyc = 0, last1 = -1;
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 5; i++) begin
            for (int k = i; k >= 0; k--) begin
                if (wcnt[i] < 8192) wb[i][wcnt[i]] = pd[i][k];
                wcnt[i]++;
            end
            cecnt[i] += int'(ce_a[i]);
            if (!rst && (int'(fill_a[i]) < i + 1 || int'(fill_a[i]) > i + 5)) viol++;
        end
        if (rst) last1 = -1;
        else if (ce_a[0]) begin
            if (last1 >= 0 && cyc - last1 != 5) gapviol++;
            last1 = cyc;
        end
    end

    int fd [16], fe [16], ex [16], got [16];

    task automatic cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a nibble and hold it until the DUT has sampled it on a tx_ce edge.
    task automatic nib(int i, logic en, logic [3:0] d, logic er);
        logic c;
        en_a[i] = en; d_a[i] = d; er_a[i] = er;
        for (int n = 0; n < 12; n++) begin
            c = ce_a[i];
            @(posedge clk);
            #1;
            if (c) return;
        end
        check($sformatf("B%0d tx_ce timeout", i + 1), 0, 1);
    endtask

    task automatic frame(int i, int n);
        for (int k = 0; k < n; k++) nib(i, 1, 4'(fd[k]), fe[k][0]);
        check($sformatf("B%0d tx in frame", i + 1), 32'(tx_a[i]), 1);
        nib(i, 0, 0, 0);
        cycles(40);
        check($sformatf("B%0d tx after frame", i + 1), 32'(tx_a[i]), 0);
    endtask

    // Align on the first zero bit (third bit of J) and slice 5-bit groups.
    task automatic groups(int i, int s, int n);
        int z = -1, idx;
        for (int k = s; k < wcnt[i] && k < 8192; k++)
            if (z < 0 && wb[i][k] == 1'b0) z = k;
        for (int k = 0; k < n; k++) begin
            got[k] = 0;
            for (int b = 0; b < 5; b++) begin
                idx = z - 2 + 5 * k + b;
                got[k] = (z < 0 || idx >= wcnt[i] || idx >= 8192) ? 99 : (got[k] << 1) | int'(wb[i][idx]);
            end
        end
    endtask

    task automatic compare(int i, int s, int n);
        groups(i, s, n);
        for (int k = 0; k < n; k++) check($sformatf("B%0d group %0d", i + 1, k), got[k], ex[k]);
    endtask

    int s, c0, c1, c4, zeros, n;
    initial begin
        for (int i = 0; i < 5; i++) begin
            link[i] = 1; en_a[i] = 0; er_a[i] = 0; d_a[i] = 0;
        end
        for (int k = 0; k < 16; k++) fe[k] = 0;
        cycles(3);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("B%0d reset pma", i + 1), pd[i], (1 << (i + 1)) - 1);
            check($sformatf("B%0d reset tx_ce", i + 1), 32'(ce_a[i]), (i == 4) ? 1 : 0);
            check($sformatf("B%0d reset tx", i + 1), 32'(tx_a[i]), 0);
        end
        rst = 0;
        cycles(5);

        // Idle: ones on the wire, tx_ce duty BITS/5.
        s = wcnt[0]; c0 = cecnt[0]; c1 = cecnt[1]; c4 = cecnt[4];
        cycles(50);
        zeros = 0;
        for (int k = s; k < wcnt[0]; k++) zeros += int'(!wb[0][k]);
        check("B1 idle zeros", zeros, 0);
        check("B1 tx_ce per 50", cecnt[0] - c0, 10);
        check("B2 tx_ce per 50", cecnt[1] - c1, 20);
        check("B5 tx_ce per 50", cecnt[4] - c4, 50);

        // BITS=2: eight 0x5 then 0xD.
        s = wcnt[1];
        for (int k = 0; k < 8; k++) fd[k] = 5;
        fd[8] = 13;
        frame(1, 9);
        ex[0] = C_J; ex[1] = C_K;
        for (int k = 2; k < 8; k++) ex[k] = 5'b01011;
        ex[8] = 5'b11011; ex[9] = C_T; ex[10] = C_R; ex[11] = C_I;
        compare(1, s, 12);

        // BITS=3: tx_er on fourth data nibble.
        s = wcnt[2];
        fd[0] = 5; fd[1] = 5; fd[2] = 1; fd[3] = 2; fd[4] = 3; fd[5] = 4; fd[6] = 6; fd[7] = 7;
        fe[5] = 1;
        frame(2, 8);
        fe[5] = 0;
        ex[0] = C_J; ex[1] = C_K; ex[2] = 5'b01001; ex[3] = 5'b10100; ex[4] = 5'b10101;
        ex[5] = C_H; ex[6] = 5'b01110; ex[7] = 5'b01111; ex[8] = C_T; ex[9] = C_R; ex[10] = C_I;
        compare(2, s, 11);
`ifdef PCS_TX_GEAR_STATS_EN
        check("B3 err_cnt", ec[2], 1);
        check("B3 frames_cnt", fc[2], 1);
`endif

        // BITS=5: tx_en and tx_er together from the first nibble.
        s = wcnt[4];
        for (int k = 0; k < 4; k++) begin fd[k] = 0; fe[k] = 1; end
        frame(4, 4);
        for (int k = 0; k < 4; k++) fe[k] = 0;
        ex[0] = C_J; ex[1] = C_K; ex[2] = C_H; ex[3] = C_H; ex[4] = C_T; ex[5] = C_R; ex[6] = C_I;
        compare(4, s, 7);
`ifdef PCS_TX_GEAR_STATS_EN
        check("B5 frames_cnt", fc[4], 1);
        check("B5 err_cnt", ec[4], 2);
`endif

        // BITS=4: link lost mid-DATA, nibble C never reaches the wire.
        s = wcnt[3];
        nib(3, 1, 4'h5, 0); nib(3, 1, 4'h5, 0); nib(3, 1, 4'hA, 0); nib(3, 1, 4'hB, 0); nib(3, 1, 4'hC, 0);
        link[3] = 0;
        nib(3, 1, 4'hD, 0);
        check("B4 tx after link loss", 32'(tx_a[3]), 0);
        link[3] = 1;
        nib(3, 0, 0, 0);
        cycles(40);
        ex[0] = C_J; ex[1] = C_K; ex[2] = 5'b10110; ex[3] = 5'b10111; ex[4] = C_I; ex[5] = C_I; ex[6] = C_I;
        compare(3, s, 7);
`ifdef PCS_TX_GEAR_STATS_EN
        check("B4 abort_cnt", ac[3], 1);
        check("B4 frames_cnt", fc[3], 1);
`endif

        // Reset mid-frame: outputs return at once, no clock needed.
        nib(3, 1, 4'h5, 0); nib(3, 1, 4'h5, 0); nib(3, 1, 4'hA, 0); nib(3, 1, 4'hB, 0);
        #2 rst = 1;
        #1;
        check("B4 rst pma", pd[3], 5'h0F);
        check("B4 rst tx", 32'(tx_a[3]), 0);
        check("B4 rst tx_ce", 32'(ce_a[3]), 0);
`ifdef PCS_TX_GEAR_STATS_EN
        check("B4 rst abort_cnt", ac[3], 0);
        check("B4 rst frames_cnt", fc[3], 0);
`endif
        en_a[3] = 0;
        cycles(2);
        rst = 0;
        cycles(10);

        // Random frames on every width against the reference table.
        for (int i = 0; i < 5; i++) begin
            s = wcnt[i];
            n = $urandom_range(10, 6);
            for (int k = 0; k < n; k++) fd[k] = $urandom_range(15, 0);
            frame(i, n);
            ex[0] = C_J; ex[1] = C_K;
            for (int k = 2; k < n; k++) ex[k] = ENC[fd[k]];
            ex[n] = C_T; ex[n+1] = C_R; ex[n+2] = C_I;
            compare(i, s, n + 3);
        end
`ifdef PCS_TX_GEAR_STATS_EN
        check("B1 frames before clr", fc[0], 1);
        clr = 1;
        cycles(1);
        clr = 0;
        check("B1 frames after clr", fc[0], 0);
        check("B5 err after clr", ec[4], 0);
`endif
        check("fill bound violations", viol, 0);
        check("B1 tx_ce spacing", gapviol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
